// File: rtl/ysyx_25040129_regfile_sb.sv
// ysyx_25040129_regfile_sb
//   Integer register file with a per-register pending-write scoreboard for the
//   pipelined NPC. x0 reads as zero, has no storage and is never busy.
//
//   Ports
//     clk, rst              clock, synchronous active-high reset
//     raddr / rdata / rbusy NRD read ports (flat vectors, port i at slice i)
//     iss_valid / iss_rd    reserve a destination register
//     iss_ready             reservation can be accepted (independent of iss_valid)
//     wen / waddr / wdata   writeback; also retires one reservation if any
//     flush                 clear every pending count, keep register contents
//
//   Build option: YSYX_25040129_RF_BYPASS_EN forwards the writeback in the same
//   cycle to matching read ports (data and hazard release). Without it no
//   output depends combinationally on wen/waddr/wdata.

// One architectural register: data plus its in-flight write count.
module ysyx_25040129_regfile_sb_slot #(
   parameter int XLEN = 32,
   parameter int CW   = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            wr,
   input  logic            inc,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] data,
   output logic [CW-1:0]   cnt
);

   // A write with nothing outstanding is unscoreboarded: data only, no retire.
   logic dec;
   assign dec = wr && (cnt != '0);

   always_ff @(posedge clk) begin
      if (rst)     data <= '0;
      else if (wr) data <= wdata;
   end

   // Issue and retire of the same register in one cycle cancel out.
   always_ff @(posedge clk) begin
      if (rst || flush)      cnt <= '0;
      else if (inc && !dec)  cnt <= cnt + CW'(1);
      else if (dec && !inc)  cnt <= cnt - CW'(1);
   end

endmodule

module ysyx_25040129_regfile_sb #(
   parameter  int XLEN     = 32,
   parameter  int NREGS    = 16,
   parameter  int NRD      = 2,
   parameter  int PEND_MAX = 3,
   localparam int AW       = $clog2(NREGS),
   localparam int CW       = $clog2(PEND_MAX + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   raddr,
   output logic [NRD*XLEN-1:0] rdata,
   output logic [NRD-1:0]      rbusy,
   input  logic                iss_valid,
   input  logic [AW-1:0]       iss_rd,
   output logic                iss_ready,
   input  logic                wen,
   input  logic [AW-1:0]       waddr,
   input  logic [XLEN-1:0]     wdata,
   input  logic                flush
);

   logic [NREGS-1:0][XLEN-1:0] reg_q;
   logic [NREGS-1:0][CW-1:0]   cnt_q;
   logic                       iss_fire;

   // Slot 0 is a constant so reads of x0 need no special case.
   assign reg_q[0] = '0;
   assign cnt_q[0] = '0;

   // cnt_q[0] is 0 and PEND_MAX >= 1, so x0 is always ready.
   assign iss_ready = (cnt_q[iss_rd] != CW'(PEND_MAX));
   assign iss_fire  = iss_valid && iss_ready;

   genvar r;
   for (r = 1; r < NREGS; r++) begin : g_slot
      logic wr_hit, iss_hit;
      assign wr_hit  = wen      && (waddr  == AW'(r));
      assign iss_hit = iss_fire && (iss_rd == AW'(r));

      ysyx_25040129_regfile_sb_slot #(
         .XLEN (XLEN),
         .CW   (CW)
      ) u_slot (
         .clk   (clk),
         .rst   (rst),
         .flush (flush),
         .wr    (wr_hit),
         .inc   (iss_hit),
         .wdata (wdata),
         .data  (reg_q[r]),
         .cnt   (cnt_q[r])
      );
   end

   genvar i;
   for (i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] ra;
      assign ra = raddr[i*AW +: AW];
`ifdef YSYX_25040129_RF_BYPASS_EN
      // The committing write retires one reservation this cycle, so the
      // hazard clears when it was the last one outstanding.
      logic fwd;
      assign fwd = wen && (waddr != '0) && (waddr == ra);
      assign rdata[i*XLEN +: XLEN] = fwd ? wdata : reg_q[ra];
      assign rbusy[i] = fwd ? (cnt_q[ra] > CW'(1)) : (cnt_q[ra] != '0);
`else
      assign rdata[i*XLEN +: XLEN] = reg_q[ra];
      assign rbusy[i] = (cnt_q[ra] != '0);
`endif
   end

endmodule

// File: tb/tb_ysyx_25040129_regfile_sb.sv
// Scoreboard bench for ysyx_25040129_regfile_sb (NREGS=32, NRD=4, PEND_MAX=3).
// Stimulus sets inputs just after a rising edge and queues the outputs it
// expects for that cycle; the monitor drains the queue at the falling edge.
module tb_ysyx_25040129_regfile_sb;
   localparam int XLEN = 32, NREGS = 32, NRD = 4, PEND_MAX = 3, AW = 5;
`ifdef YSYX_25040129_RF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst;
   logic [NRD*AW-1:0]   raddr;
   logic [NRD*XLEN-1:0] rdata;
   logic [NRD-1:0]      rbusy;
   logic                iss_valid;
   logic [AW-1:0]       iss_rd;
   logic                iss_ready;
   logic                wen;
   logic [AW-1:0]       waddr;
   logic [XLEN-1:0]     wdata;
   logic                flush;

   ysyx_25040129_regfile_sb #(
      .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .PEND_MAX(PEND_MAX)
   ) dut (
      .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
      .wen(wen), .waddr(waddr), .wdata(wdata), .flush(flush)
   );

   always #5 clk = ~clk;

   // kind: 0 = rdata of port, 1 = rbusy vector, 2 = iss_ready
   typedef struct {
      string       name;
      int          kind;
      int          port;
      logic [31:0] exp;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   always @(negedge clk) begin : monitor
      exp_t        e;
      logic [31:0] act;
      while (q.size() > 0) begin
         e = q.pop_front();
         case (e.kind)
            0:       act = rdata[e.port*XLEN +: XLEN];
            1:       act = {28'd0, rbusy};
            default: act = {31'd0, iss_ready};
         endcase
         checks++;
         if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
         end
      end
   end

   task automatic exp_rd(input string n, input int p, input logic [31:0] v);
      exp_t e;
      e.name = n; e.kind = 0; e.port = p; e.exp = v;
      q.push_back(e);
   endtask

   task automatic exp_busy(input string n, input logic [3:0] v);
      exp_t e;
      e.name = n; e.kind = 1; e.port = 0; e.exp = {28'd0, v};
      q.push_back(e);
   endtask

   task automatic exp_rdy(input string n, input logic v);
      exp_t e;
      e.name = n; e.kind = 2; e.port = 0; e.exp = {31'd0, v};
      q.push_back(e);
   endtask

   task automatic idle();
      rst = 1'b0; raddr = '0; iss_valid = 1'b0; iss_rd = '0;
      wen = 1'b0; waddr = '0; wdata = '0; flush = 1'b0;
   endtask

   task automatic rd4(input int a0, input int a1, input int a2, input int a3);
      raddr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      wen = 1'b1; waddr = AW'(a); wdata = d;
   endtask

   task automatic iss(input int a);
      iss_valid = 1'b1; iss_rd = AW'(a);
   endtask

   // Advance one edge; inputs for the next cycle start from idle.
   task automatic step();
      @(posedge clk); #1;
      idle();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      step();

      // Post-reset: every register reads 0, nothing busy, issue ready.
      for (int a = 0; a < NREGS; a += 4) begin
         rd4(a, a + 1, a + 2, a + 3);
         iss_rd = AW'(a + 1);
         for (int p = 0; p < NRD; p++) exp_rd("reset_rdata", p, 32'd0);
         exp_busy("reset_rbusy", 4'b0000);
         exp_rdy("reset_ready", 1'b1);
         step();
      end

      // Write to x0 is dropped.
      wr(0, 32'hDEADBEEF);
      exp_rd("x0_write_cycle", 0, 32'd0);
      step();
      exp_rd("x0_after_write", 0, 32'd0);
      step();

      // x5 write: visible next cycle, or same cycle with forwarding.
      wr(5, 32'h12345678); rd4(5, 0, 0, 0);
      exp_rd("x5_same_cycle", 0, BYP ? 32'h12345678 : 32'd0);
      step();
      rd4(5, 0, 0, 0);
      exp_rd("x5_next_cycle", 0, 32'h12345678);
      step();

      // Fill x7 to PEND_MAX; port 1 watches it.
      for (int k = 0; k < 3; k++) begin
         iss(7); rd4(0, 7, 0, 0);
         exp_busy("x7_issue_busy", (k == 0) ? 4'b0000 : 4'b0010);
         exp_rdy("x7_issue_ready", 1'b1);
         step();
      end
      iss(7); rd4(0, 7, 0, 0);
      exp_busy("x7_full_busy", 4'b0010);
      exp_rdy("x7_full_ready_valid", 1'b0);
      step();
      iss_rd = AW'(7); rd4(0, 7, 0, 0);
      exp_rdy("x7_full_ready_novalid", 1'b0);
      step();
      // Three commits; count goes 3,2,1 during the commit cycles.
      for (int k = 0; k < 3; k++) begin
         wr(7, 32'h00000077); rd4(0, 7, 0, 0);
         exp_busy("x7_commit_busy", (BYP && k == 2) ? 4'b0000 : 4'b0010);
         step();
      end
      rd4(0, 7, 0, 0); iss_rd = AW'(7);
      exp_busy("x7_released", 4'b0000);
      exp_rdy("x7_ready_again", 1'b1);
      exp_rd("x7_data", 1, 32'h00000077);
      step();

      // x9: issue, then issue+commit in one cycle leaves count at 1.
      iss(9);
      step();
      iss(9); wr(9, 32'h00000099); rd4(9, 0, 0, 0);
      exp_busy("x9_iss_commit_busy", BYP ? 4'b0000 : 4'b0001);
      exp_rd("x9_iss_commit_data", 0, BYP ? 32'h00000099 : 32'd0);
      step();
      rd4(9, 0, 0, 0);
      exp_busy("x9_still_pending", 4'b0001);
      exp_rd("x9_written", 0, 32'h00000099);
      step();
      // Flush with an issue to x9 and a write to x10 in the same cycle.
      iss(9); flush = 1'b1; wr(10, 32'h0000A0A0); rd4(9, 0, 0, 0);
      exp_busy("x9_flush_cycle", 4'b0001);
      step();
      rd4(9, 10, 0, 0); iss_rd = AW'(9);
      exp_busy("x9_flushed", 4'b0000);
      exp_rdy("x9_ready_after_flush", 1'b1);
      exp_rd("x9_kept_after_flush", 0, 32'h00000099);
      exp_rd("x10_write_during_flush", 1, 32'h0000A0A0);
      step();

      // Unscoreboarded write to x3.
      wr(3, 32'h00000033); iss_rd = AW'(3);
      exp_rdy("x3_ready_write_cycle", 1'b1);
      step();
      rd4(3, 0, 0, 0); iss_rd = AW'(3);
      exp_rd("x3_data", 0, 32'h00000033);
      exp_busy("x3_not_busy", 4'b0000);
      exp_rdy("x3_ready", 1'b1);
      step();

      // Different registers: issue x13 while committing x12.
      iss(12);
      step();
      iss(13); wr(12, 32'h00001212);
      step();
      rd4(12, 13, 0, 0);
      exp_busy("x12_x13_indep", 4'b0010);
      step();
      wr(13, 32'h00001313);
      step();

      // Four ports with x16 pending.
      wr(16, 32'h00001616);
      step();
      iss(16); wr(31, 32'hF0F03131);
      step();
      rd4(31, 0, 16, 31);
      exp_rd("p0_x31", 0, 32'hF0F03131);
      exp_rd("p1_x0",  1, 32'd0);
      exp_rd("p2_x16", 2, 32'h00001616);
      exp_rd("p3_x31", 3, 32'hF0F03131);
      exp_busy("four_port_busy", 4'b0100);
      step();

      // Reset mid-sequence; write and issue in that cycle are ignored.
      rst = 1'b1; wr(5, 32'h00000055); iss(20);
      step();
      rd4(31, 16, 5, 20); iss_rd = AW'(16);
      for (int p = 0; p < NRD; p++) exp_rd("midreset_rdata", p, 32'd0);
      exp_busy("midreset_busy", 4'b0000);
      exp_rdy("midreset_ready", 1'b1);
      step();

      @(negedge clk); #1;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got %0d entries expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_25040129_regfile_sb.md
# ysyx_25040129_regfile_sb

Parametrised integer register file with a per-register pending-write scoreboard, the next generation of the core's single-cycle register file, for the pipelined NPC. It provides NRD combinational read ports, one write (writeback/commit) port, one issue port that reserves destination registers, and a flush input. Decode uses it for operand reads and RAW hazard detection. x0 is hard-wired to zero and is never busy.

## Interface
- XLEN, 32: register width in bits.
- NREGS, 16: architectural register count; legal values are 16 (RV32E) and 32 (RV32I). AW = $clog2(NREGS) is derived, not a parameter.
- NRD, 2: number of read ports, 1..4.
- PEND_MAX, 3: maximum in-flight writes per register, 1..7. Counter width CW = $clog2(PEND_MAX+1).

- clk  in  1  clock. One clock domain. Reset is synchronous and active-high.
- rst  in  1  synchronous reset, active-high.
- raddr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- rdata  out  NRD*XLEN  read data for port i.
- rbusy  out  NRD  port i's register has a pending write.
- iss_valid  in  1  issue request reserving iss_rd.
- iss_rd  in  AW  destination register to reserve.
- iss_ready  out  1  issue can be accepted.
- wen  in  1  writeback/commit strobe.
- waddr  in  AW  writeback register.
- wdata  in  XLEN  writeback data.
- flush  in  1  clear all pending counts; register contents are kept.

## Operation
- Storage is regs[1..NREGS-1], XLEN each, plus cnt[1..NREGS-1], CW bits each. Index 0 has no storage.
- Read: rdata[i] = 0 if raddr[i]==0, otherwise regs[raddr[i]]. Purely combinational.
- rbusy[i] = (raddr[i]!=0) && (cnt[raddr[i]]!=0), with the bypass adjustment described under Configuration.
- Write: on a clock edge with wen && waddr!=0, regs[waddr] <= wdata. A write to x0 is ignored.
- Commit: on a clock edge with wen && waddr!=0 && cnt[waddr]!=0, cnt is decremented. A write while cnt==0 is an unscoreboarded write: data is written and the count stays 0.
- iss_ready = (iss_rd==0) || (cnt[iss_rd]!=PEND_MAX). It is combinational and must not depend on iss_valid.
- Issue fires on iss_valid && iss_ready. For iss_rd!=0 the count is incremented. Firing with iss_rd==0 is a no-op.
- Same register, issue fire and commit in the same cycle: the count is unchanged.
- Different registers, issue fire and commit in the same cycle: each count is updated independently.
- flush: all counts go to 0 on the next edge. Any issue in the same cycle is discarded. A write in the same cycle still updates regs.
- Priority for the count update: rst > flush > (increment/decrement).

## Timing
- Reset (synchronous, rst high at an edge): all regs are set to 0 and all cnt to 0.
- Outputs after reset: rdata = 0, rbusy = 0, iss_ready = 1.
- Read latency is 0 cycles.
- Without bypass, written data is visible on rdata the cycle after the wen edge.
- An issued reservation is visible on rbusy the cycle after the fire edge.
- rst asserted mid-operation discards pending counts and data; iss_valid and wen in that cycle are ignored.
- No combinational path from iss_valid to iss_ready or to rbusy.

## Configuration
- YSYX_25040129_RF_BYPASS_EN defined: same-cycle write forwarding. When wen && waddr!=0 && waddr==raddr[i]:
  - rdata[i] = wdata in the same cycle;
  - rbusy[i] = (cnt[raddr[i]] > 1), i.e. the committing write releases the hazard in that cycle.
- Macro undefined: no forwarding. rdata shows the old value and rbusy still reflects cnt until the edge. There is no combinational path from wen/waddr/wdata to any output.

## Test plan
- Reset, then read all registers on all ports -> every rdata = 0, rbusy = 0, iss_ready = 1. Write x0 with 0xDEADBEEF -> port read of x0 is still 0.
- Write x5 = 0x12345678, read x5 on port 0 in the same cycle and the next cycle:
  - with bypass -> 0x12345678 in both cycles;
  - without bypass -> 0 in the write cycle, 0x12345678 in the next.
- Issue x7 three times (PEND_MAX=3):
  - after the third fire -> rbusy=1 for x7 and iss_ready=0 while iss_rd=7;
  - after three commits to x7 -> rbusy=0.
- Same-cycle issue and commit to x9 with cnt=1 -> cnt stays 1 and rbusy stays 1. Issue x9 with flush high -> cnt=0 next cycle and rbusy=0.
- Unscoreboarded write to x3 with cnt=0 -> data is written, cnt stays 0, iss_ready=1.
- NREGS=32, NRD=4: four ports read x31, x0, x16 and x31 while x16 is pending -> correct data on each port and rbusy=4'b0100. Assert rst mid-sequence -> all cleared next cycle.
